// File: rtl/pong_score_keeper_if.sv
// pong_score_keeper_if: game-control signals between ball engine, score keeper and display
interface pong_score_keeper_if;
  logic       frame_tick;
  logic       start;
  logic       score1;
  logic       score2;
  logic       ball_rst;
  logic       play_en;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic [1:0] winner;
  logic [6:0] seg;
  logic [3:0] an;
  modport master (
    output frame_tick, start, score1, score2,
    input  ball_rst, play_en, p1_score, p2_score, game_over, winner, seg, an
  );
  modport slave (
    input  frame_tick, start, score1, score2,
    output ball_rst, play_en, p1_score, p2_score, game_over, winner, seg, an
  );
endinterface

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: serve/pause/game-over FSM with point counters; SCORE_7SEG_EN adds the 4-digit score display
module pong_score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int SEG_DIV_BITS = 18
) (
  input logic            clk,
  input logic            reset,
  pong_score_keeper_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;
  if (WIN_SCORE < 1 || WIN_SCORE > 9 || PAUSE_FRAMES < 1 || PAUSE_FRAMES > 255 || SEG_DIV_BITS < 2) begin : g_bad_params
    $error("pong_score_keeper: parameter out of legal range");
  end
  logic [1:0] state, state_n;
  logic       score1_q, score2_q;
  logic [7:0] pause_cnt;
  logic [3:0] p1, p2;
  logic [1:0] winner;
  logic       edge1, edge2, p1_wins, p2_wins;
  logic [3:0] p1_inc, p2_inc;
  assign edge1   = bus.score1 & ~score1_q;
  assign edge2   = bus.score2 & ~score2_q;
  assign p1_inc  = p1 + 4'd1;
  assign p2_inc  = p2 + 4'd1;
  assign p1_wins = p1_inc == 4'(WIN_SCORE);
  assign p2_wins = p2_inc == 4'(WIN_SCORE);
  always_comb begin
    state_n = state == IDLE  ? (bus.start ? PLAY : IDLE) :
              state == PLAY  ? (edge1 ? (p1_wins ? OVER : PAUSE) :
                                edge2 ? (p2_wins ? OVER : PAUSE) : PLAY) :
              state == PAUSE ? (bus.frame_tick && pause_cnt == 8'd1 ? PLAY : PAUSE) :
                               (bus.start ? PLAY : OVER);
  end
  // edge1 wins a tie with edge2; the losing edge is simply dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      score1_q  <= 1'b0;
      score2_q  <= 1'b0;
      pause_cnt <= 8'd0;
      p1        <= 4'd0;
      p2        <= 4'd0;
      winner    <= 2'b00;
    end else begin
      state    <= state_n;
      score1_q <= bus.score1;
      score2_q <= bus.score2;
      pause_cnt <= state == PLAY && state_n == PAUSE ? 8'(PAUSE_FRAMES) :
                   state == PAUSE && bus.frame_tick ? pause_cnt - 8'd1 : pause_cnt;
      if (state == PLAY && edge1) begin
        p1 <= p1_inc;
        if (p1_wins) winner <= 2'b01;
      end else if (state == PLAY && edge2) begin
        p2 <= p2_inc;
        if (p2_wins) winner <= 2'b10;
      end else if (state == OVER && bus.start) begin
        p1     <= 4'd0;
        p2     <= 4'd0;
        winner <= 2'b00;
      end
    end
  end
  assign bus.ball_rst  = state != PLAY;
  assign bus.play_en   = state == PLAY;
  assign bus.game_over = state == OVER;
  assign bus.p1_score  = p1;
  assign bus.p2_score  = p2;
  assign bus.winner    = winner;
`ifdef SCORE_7SEG_EN
  logic [SEG_DIV_BITS-1:0] div;
  logic [1:0]              dig;
  logic [6:0]              seg_n, seg_r;
  logic [3:0]              an_r;
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: enc = 7'h40;
      4'd1: enc = 7'h79;
      4'd2: enc = 7'h24;
      4'd3: enc = 7'h30;
      4'd4: enc = 7'h19;
      4'd5: enc = 7'h12;
      4'd6: enc = 7'h02;
      4'd7: enc = 7'h78;
      4'd8: enc = 7'h00;
      4'd9: enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction
  // select field 0,1,2,3 lights digits 3,2,1,0
  assign dig = ~div[SEG_DIV_BITS-1 -: 2];
  always_comb begin
    seg_n = dig == 2'd3 ? enc(p1) :
            dig == 2'd0 ? enc(p2) :
            state == IDLE ? 7'h7F : 7'h3F;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      seg_r <= 7'h7F;
      an_r  <= 4'hF;
    end else begin
      div   <= div + 1'b1;
      seg_r <= seg_n;
      an_r  <= ~(4'b0001 << dig);
    end
  end
  assign bus.seg = seg_r;
  assign bus.an  = an_r;
`else
  assign bus.seg = 7'h7F;
  assign bus.an  = 4'hF;
`endif
endmodule

// File: tb/tb_pong_score_keeper.sv
// tb_pong_score_keeper: directed stimulus against a cycle-level game model plus literal spot checks
module tb_pong_score_keeper;
  localparam int WIN = 7;
  localparam int PF  = 60;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  pong_score_keeper_if bus();
  pong_score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF), .SEG_DIV_BITS(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef enum int {M_IDLE, M_PLAY, M_PAUSE, M_OVER} mst_t;
  mst_t m_st;
  int m_p1, m_p2, m_win, m_left, m_div;
  logic m_q1, m_q2;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  function automatic logic [6:0] digit_code(int v);
    case (v)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction
  function automatic logic [6:0] shown(int d);
    if (d == 3) return digit_code(m_p1);
    if (d == 0) return digit_code(m_p2);
    return m_st == M_IDLE ? 7'h7F : 7'h3F;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= M_IDLE; m_p1 <= 0; m_p2 <= 0; m_win <= 0; m_left <= 0;
      m_q1 <= 1'b0; m_q2 <= 1'b0; m_div <= 0; m_seg <= 7'h7F; m_an <= 4'hF;
    end else begin
      m_q1 <= bus.score1;
      m_q2 <= bus.score2;
      case (m_st)
        M_IDLE: if (bus.start) m_st <= M_PLAY;
        M_PLAY:
          if (bus.score1 && !m_q1) begin
            m_p1 <= m_p1 + 1;
            if (m_p1 + 1 == WIN) begin m_st <= M_OVER; m_win <= 1; end
            else begin m_st <= M_PAUSE; m_left <= PF; end
          end else if (bus.score2 && !m_q2) begin
            m_p2 <= m_p2 + 1;
            if (m_p2 + 1 == WIN) begin m_st <= M_OVER; m_win <= 2; end
            else begin m_st <= M_PAUSE; m_left <= PF; end
          end
        M_PAUSE:
          if (bus.frame_tick) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_st <= M_PLAY;
          end
        M_OVER:
          if (bus.start) begin m_p1 <= 0; m_p2 <= 0; m_win <= 0; m_st <= M_PLAY; end
      endcase
`ifdef SCORE_7SEG_EN
      m_div <= (m_div + 1) % (1 << DIV);
      m_an  <= ~(4'b0001 << (3 - m_div / (1 << (DIV - 2))));
      m_seg <= shown(3 - m_div / (1 << (DIV - 2)));
`endif
    end
  end
  always @(negedge clk) begin
    chk("ball_rst", bus.ball_rst, m_st != M_PLAY);
    chk("play_en", bus.play_en, m_st == M_PLAY);
    chk("game_over", bus.game_over, m_st == M_OVER);
    chk("p1_score", bus.p1_score, m_p1);
    chk("p2_score", bus.p2_score, m_p2);
    chk("winner", bus.winner, m_win);
    chk("seg", bus.seg, m_seg);
    chk("an", bus.an, m_an);
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic ticks(int n);
    repeat (n) begin bus.frame_tick = 1'b1; cyc(1); bus.frame_tick = 1'b0; cyc(2); end
  endtask
  task automatic hit(logic a, logic b);
    bus.score1 = a; bus.score2 = b; cyc(1); bus.score1 = 1'b0; bus.score2 = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
  endtask
  task automatic wait_play(string name);
    int k = 0;
    while (!bus.play_en && k < 400) begin cyc(1); k++; end
    chk(name, bus.play_en, 1);
  endtask
  task automatic reset_literals(string tag);
    chk({tag, "_ball_rst"}, bus.ball_rst, 1);
    chk({tag, "_play_en"}, bus.play_en, 0);
    chk({tag, "_p1"}, bus.p1_score, 0);
    chk({tag, "_p2"}, bus.p2_score, 0);
    chk({tag, "_over"}, bus.game_over, 0);
    chk({tag, "_winner"}, bus.winner, 0);
    chk({tag, "_seg"}, bus.seg, 7'h7F);
    chk({tag, "_an"}, bus.an, 4'hF);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.frame_tick = 1'b0; bus.start = 1'b0; bus.score1 = 1'b0; bus.score2 = 1'b0;
    cyc(3);
    reset_literals("rst");
    reset = 1'b0;
    cyc(2);
    chk("idle_ball_rst", bus.ball_rst, 1);
    pulse_start();
    chk("start_play_en", bus.play_en, 1);
    chk("start_ball_rst", bus.ball_rst, 0);
    chk("start_p1", bus.p1_score, 0);
    chk("start_p2", bus.p2_score, 0);
    bus.score1 = 1'b1; bus.frame_tick = 1'b1;
    cyc(1);
    bus.frame_tick = 1'b0;
    chk("edge_p1", bus.p1_score, 1);
    chk("edge_pause", bus.ball_rst, 1);
    cyc(2);
    ticks(3);
    chk("held_once_p1", bus.p1_score, 1);
    bus.score1 = 1'b0;
    ticks(PF - 4);
    chk("pause_59", bus.ball_rst, 1);
    ticks(1);
    chk("pause_60", bus.ball_rst, 0);
    pulse_start();
    chk("start_in_play", bus.play_en, 1);
    hit(1'b0, 1'b1);
    chk("p2_point", bus.p2_score, 1);
    ticks(10);
    @(posedge clk); #4;
    reset = 1'b1;
    #1;
    reset_literals("async");
    cyc(1);
    reset = 1'b0;
    cyc(1);
    pulse_start();
    chk("resume_play_en", bus.play_en, 1);
    hit(1'b1, 1'b1);
    chk("tie_p1", bus.p1_score, 1);
    chk("tie_p2", bus.p2_score, 0);
    ticks(PF);
    wait_play("tie_resume");
    for (int i = 0; i < WIN; i++) begin
      hit(1'b0, 1'b1);
      if (i < WIN - 1) begin ticks(PF); wait_play("p2_resume"); end
    end
    chk("win_over", bus.game_over, 1);
    chk("win_winner", bus.winner, 2);
    chk("win_p2", bus.p2_score, 7);
    chk("win_p1", bus.p1_score, 1);
    cyc(2);
    hit(1'b0, 1'b1);
    cyc(1);
    chk("over_p2_held", bus.p2_score, 7);
    chk("over_winner_held", bus.winner, 2);
    pulse_start();
    chk("restart_p1", bus.p1_score, 0);
    chk("restart_p2", bus.p2_score, 0);
    chk("restart_winner", bus.winner, 0);
    chk("restart_play", bus.play_en, 1);
`ifdef SCORE_7SEG_EN
    begin
      bit s3 = 1'b0, s0 = 1'b0;
      for (int i = 0; i < 3; i++) begin hit(1'b1, 1'b0); ticks(PF); wait_play("d_p1"); end
      for (int i = 0; i < 5; i++) begin hit(1'b0, 1'b1); ticks(PF); wait_play("d_p2"); end
      cyc(2);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.an == 4'b0111) begin chk("digit3_seg", bus.seg, 7'h30); s3 = 1'b1; end
        if (bus.an == 4'b1110) begin chk("digit0_seg", bus.seg, 7'h12); s0 = 1'b1; end
      end
      chk("digit3_seen", s3, 1);
      chk("digit0_seen", s0, 1);
    end
`endif
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_score_keeper.md
# pong_score_keeper

Game-control stage downstream of the ball engine. It edge-detects the per-frame `score1`/`score2` flags and keeps per-player point counts. It sequences serve, pause and game-over through a Moore FSM and drives the ball engine's serve/reset request. An optional multiplexed driver shows both scores on the Basys 3 four-digit seven-segment display.

## Interface
- `WIN_SCORE`, 7: points needed to win; legal range 1..9.
- `PAUSE_FRAMES`, 60: frame ticks the ball is held between points; legal range 1..255.
- `SEG_DIV_BITS`, 18: width of the display refresh counter. Its top 2 bits select the digit.
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `frame_tick` in 1: one-`clk` pulse per video frame, the same tick the ball engine uses.
- `start` in 1: debounced single-`clk` pulse from the start button.
- `score1` in 1: level flag from the ball engine; high while the ball is past the right border.
- `score2` in 1: level flag from the ball engine; high while the ball is past the left border.
- `ball_rst` out 1: high = hold the ball at the serve position; routed to the ball engine reset.
- `play_en` out 1: high only in PLAY. Enables paddle movement.
- `p1_score` out 4: player 1 points, binary 0..WIN_SCORE.
- `p2_score` out 4: player 2 points, binary 0..WIN_SCORE.
- `game_over` out 1: high in OVER.
- `winner` out 2: 00 none, 01 player 1, 10 player 2.
- `seg` out 7: segment cathodes, active-low, `seg[6:0]` = g..a.
- `an` out 4: digit anodes, active-low, `an[3]` = leftmost digit.

## Operation
- FSM states: IDLE, PLAY, PAUSE, OVER. All outputs are registered or decoded from the state register only (Moore).
- IDLE:
  - Scores are 0, `ball_rst`=1, `play_en`=0.
  - `start` moves to PLAY.
- PLAY:
  - `ball_rst`=0, `play_en`=1.
  - `edge1 = score1 & ~score1_q`; `edge2 = score2 & ~score2_q`.
  - `score1_q` and `score2_q` update every cycle in every state, so a flag held high across states never produces an edge on entry.
  - On `edge1`, `p1_score` increments. If the new value equals `WIN_SCORE`, go to OVER with `winner`=01; otherwise go to PAUSE.
  - `edge2` is symmetric for `p2_score`, with `winner`=10.
  - If `edge1` and `edge2` occur in the same cycle, `edge1` has priority and `edge2` is discarded.
- PAUSE:
  - `ball_rst`=1, `play_en`=0.
  - The 8-bit down-counter is loaded with `PAUSE_FRAMES` on entry and decrements on each `frame_tick`.
  - When it is 1 and a `frame_tick` arrives, go to PLAY.
  - Score edges are ignored.
  - `start` is ignored.
- OVER:
  - `ball_rst`=1, `play_en`=0, `game_over`=1. `winner` and the scores are held.
  - `start` clears both scores and `winner` and goes directly to PLAY.
- Counters never exceed `WIN_SCORE`, so no wrap occurs.
- `start` in PLAY is ignored.
- Reset at any time, including mid-PAUSE or during a score edge, returns to IDLE and clears all state.

## Timing
- Reset values:
  - state IDLE
  - `ball_rst`=1, `play_en`=0
  - `p1_score`=0, `p2_score`=0
  - `game_over`=0, `winner`=00
  - `score1_q`=0, `score2_q`=0
  - pause counter 0, display counter 0
  - `seg`=7'h7F, `an`=4'hF
- A score edge is seen in the same cycle `scoreN` rises. The score and state update on the next `clk` edge, and `ball_rst` rises 1 cycle after the rising `scoreN` sample.
- From a `start` pulse to `play_en`=1 is 1 cycle.
- From entering PAUSE to returning to PLAY is exactly `PAUSE_FRAMES` `frame_tick` pulses. `ball_rst` falls 1 cycle after the final tick.
- A `frame_tick` coinciding with PAUSE entry is not counted.

## Configuration
- `SCORE_7SEG_EN` defined:
  - A free-running `SEG_DIV_BITS`-bit counter steps through the digits 3, 2, 1, 0, one digit active at a time.
  - Digit 3 shows `p1_score` and digit 0 shows `p2_score`.
  - Digits 2 and 1 show a dash (`seg`=7'h3F) in PLAY, PAUSE and OVER, and are blank in IDLE.
  - Encoding: 0 = 7'h40, 1 = 7'h79, through 9 = 7'h10.
- `SCORE_7SEG_EN` undefined:
  - Counter and decoder are not compiled.
  - `seg` is tied to 7'h7F and `an` to 4'hF.
  - Ports remain present.

## Test plan
- Reset, then `start` pulse → `play_en`=1 and `ball_rst`=0 one cycle later; both scores 0.
- In PLAY, `score1` rises and is held for 3 frames → `p1_score`=1 exactly once and state PAUSE. After 60 `frame_tick`s (`PAUSE_FRAMES`=60), `ball_rst`=0.
- `score1` and `score2` rise in the same cycle → `p1_score`=1, `p2_score`=0.
- Player 2 scores 7 points (`WIN_SCORE`=7) → `game_over`=1, `winner`=10, `p2_score`=7. A further `score2` edge → no change. `start` → scores 0, `winner`=00, PLAY.
- Reset asserted asynchronously mid-PAUSE → all outputs at reset values immediately, before the next `clk` edge. After release, `start` resumes normally.
- With `SCORE_7SEG_EN`, `p1_score`=3 and `p2_score`=5 → `an`=4'b0111 paired with `seg`=7'h30, and `an`=4'b1110 paired with `seg`=7'h12.
